// File: rtl/img_rsz_blk_compute_pkg.sv
// ImgRszPkg: resized-image geometry and compute-stage state encoding.
`default_nettype none
package ImgRszPkg;
  localparam int RSZ_IMG_WIDTH_SIZE   = 4;
  localparam int RSZ_IMG_HEIGHT_SIZE  = 3;
  localparam int RSZ_IMG_WIDTH_IDX_W  = $clog2(RSZ_IMG_WIDTH_SIZE);
  localparam int RSZ_IMG_HEIGHT_IDX_W = $clog2(RSZ_IMG_HEIGHT_SIZE);
  localparam int RSZ_PXL_NUM          = RSZ_IMG_WIDTH_SIZE * RSZ_IMG_HEIGHT_SIZE;
  localparam int RSZ_PXL_CNT_W        = $clog2(RSZ_PXL_NUM);

  typedef enum logic [1:0] {
    RSZ_COMP_IDLE    = 2'd0,
    RSZ_COMP_RD_WAIT = 2'd1,
    RSZ_COMP_CALC    = 2'd2,
    RSZ_COMP_OUT     = 2'd3
  } RszCompSt_t;
endpackage
`default_nettype wire

// File: rtl/img_rsz_blk_compute_avg.sv
// img_rsz_blk_avg: block sum -> averaged pixel (shift, saturate).
// Define RSZ_COMP_ROUND_EN for round-half-up instead of truncation.
`default_nettype none
module img_rsz_blk_avg #(
  parameter int PXL_W       = 8,
  parameter int BLK_PXL_NUM = 4,
  parameter int ACC_W       = 10
) (
  input  logic [ACC_W-1:0] i_sum,
  output logic [PXL_W-1:0] o_pxl
);
  localparam int SHIFT = $clog2(BLK_PXL_NUM);

  // One spare bit so the rounding offset cannot wrap a full-scale sum.
  logic [ACC_W:0] w_sum_ext;
  logic [ACC_W:0] w_shifted;

`ifdef RSZ_COMP_ROUND_EN
  assign w_sum_ext = {1'b0, i_sum} + (ACC_W+1)'(BLK_PXL_NUM / 2);
`else
  assign w_sum_ext = {1'b0, i_sum};
`endif

  assign w_shifted = w_sum_ext >> SHIFT;

  always_comb begin
    o_pxl = w_shifted[PXL_W-1:0];
    if (w_shifted > (ACC_W+1)'((1 << PXL_W) - 1)) begin
      o_pxl = '1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/img_rsz_blk_compute.sv
// img_rsz_blk_compute: per-block read of accumulated sum, average, emit resized pixel.
// Optional rounding enabled by macro RSZ_COMP_ROUND_EN.
`default_nettype none
module img_rsz_blk_compute
  import ImgRszPkg::*;
#(
  parameter int PXL_W       = 8,
  parameter int BLK_PXL_NUM = 4,
  parameter int ACC_W       = 10
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic [RSZ_IMG_WIDTH_IDX_W-1:0]  CompBlkXIdx,
  input  logic [RSZ_IMG_HEIGHT_IDX_W-1:0] CompBlkYIdx,
  input  logic                            CompBlkVld,
  output logic                            CompBlkRdy,
  output logic                            AccRdEn,
  output logic [RSZ_IMG_WIDTH_IDX_W-1:0]  AccRdXIdx,
  output logic [RSZ_IMG_HEIGHT_IDX_W-1:0] AccRdYIdx,
  input  logic [ACC_W-1:0]                AccRdData,
  output logic [PXL_W-1:0]                RszPxlData,
  output logic [RSZ_IMG_WIDTH_IDX_W-1:0]  RszPxlXIdx,
  output logic [RSZ_IMG_HEIGHT_IDX_W-1:0] RszPxlYIdx,
  output logic                            RszPxlVld,
  input  logic                            RszPxlRdy,
  output logic                            RszFrmDone
);
  RszCompSt_t                      r_st;
  RszCompSt_t                      w_st_nxt;
  logic [RSZ_IMG_WIDTH_IDX_W-1:0]  r_x;
  logic [RSZ_IMG_HEIGHT_IDX_W-1:0] r_y;
  logic [ACC_W-1:0]                r_sum;
  logic [PXL_W-1:0]                r_pxl;
  logic [PXL_W-1:0]                w_avg;
  logic [RSZ_PXL_CNT_W-1:0]        r_cnt;
  logic                            w_req_hs;
  logic                            w_out_hs;
  logic                            w_cnt_last;

  img_rsz_blk_avg #(
    .PXL_W       (PXL_W),
    .BLK_PXL_NUM (BLK_PXL_NUM),
    .ACC_W       (ACC_W)
  ) u_avg (
    .i_sum (r_sum),
    .o_pxl (w_avg)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_st <= RSZ_COMP_IDLE;
    end else begin
      r_st <= w_st_nxt;
    end
  end

  always_comb begin
    w_st_nxt   = r_st;
    CompBlkRdy = 1'b0;
    RszPxlVld  = 1'b0;
    case (r_st)
      RSZ_COMP_IDLE: begin
        CompBlkRdy = 1'b1;
        if (CompBlkVld) w_st_nxt = RSZ_COMP_RD_WAIT;
      end
      RSZ_COMP_RD_WAIT: w_st_nxt = RSZ_COMP_CALC;
      RSZ_COMP_CALC:    w_st_nxt = RSZ_COMP_OUT;
      RSZ_COMP_OUT: begin
        RszPxlVld = 1'b1;
        if (RszPxlRdy) w_st_nxt = RSZ_COMP_IDLE;
      end
      default: w_st_nxt = RSZ_COMP_IDLE;
    endcase
  end

  assign w_req_hs   = CompBlkVld & CompBlkRdy;
  assign w_out_hs   = RszPxlVld & RszPxlRdy;
  assign w_cnt_last = (r_cnt == RSZ_PXL_CNT_W'(RSZ_PXL_NUM - 1));

  // Read address is forwarded in the handshake cycle so data lands in RD_WAIT.
  assign AccRdEn    = w_req_hs;
  assign AccRdXIdx  = w_req_hs ? CompBlkXIdx : '0;
  assign AccRdYIdx  = w_req_hs ? CompBlkYIdx : '0;
  assign RszPxlData = r_pxl;
  assign RszPxlXIdx = r_x;
  assign RszPxlYIdx = r_y;
  assign RszFrmDone = w_out_hs & w_cnt_last;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_x   <= '0;
      r_y   <= '0;
      r_sum <= '0;
      r_pxl <= '0;
      r_cnt <= '0;
    end else begin
      if (w_req_hs) begin
        r_x <= CompBlkXIdx;
        r_y <= CompBlkYIdx;
      end
      if (r_st == RSZ_COMP_RD_WAIT) r_sum <= AccRdData;
      if (r_st == RSZ_COMP_CALC)    r_pxl <= w_avg;
      if (w_out_hs) begin
        r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_img_rsz_blk_compute.sv
// Self-checking bench for img_rsz_blk_compute with a behavioural sum/average model.
`default_nettype none
module tb_img_rsz_blk_compute;
  import ImgRszPkg::*;

  localparam int W = RSZ_IMG_WIDTH_SIZE;
  localparam int H = RSZ_IMG_HEIGHT_SIZE;
  localparam int N = W * H;

  logic                            Clk = 1'b0;
  logic                            Reset = 1'b0;
  logic [RSZ_IMG_WIDTH_IDX_W-1:0]  CompBlkXIdx = '0;
  logic [RSZ_IMG_HEIGHT_IDX_W-1:0] CompBlkYIdx = '0;
  logic                            CompBlkVld = 1'b0;
  logic                            CompBlkRdy;
  logic                            AccRdEn;
  logic [RSZ_IMG_WIDTH_IDX_W-1:0]  AccRdXIdx;
  logic [RSZ_IMG_HEIGHT_IDX_W-1:0] AccRdYIdx;
  logic [9:0]                      AccRdData = '0;
  logic [7:0]                      RszPxlData;
  logic [RSZ_IMG_WIDTH_IDX_W-1:0]  RszPxlXIdx;
  logic [RSZ_IMG_HEIGHT_IDX_W-1:0] RszPxlYIdx;
  logic                            RszPxlVld;
  logic                            RszPxlRdy = 1'b1;
  logic                            RszFrmDone;

  int checks = 0;
  int failures = 0;
  int m_cnt = 0;
  int done_seen = 0;
  logic [9:0] mem [0:W-1][0:H-1];

  img_rsz_blk_compute dut (
    .Clk(Clk), .Reset(Reset),
    .CompBlkXIdx(CompBlkXIdx), .CompBlkYIdx(CompBlkYIdx),
    .CompBlkVld(CompBlkVld), .CompBlkRdy(CompBlkRdy),
    .AccRdEn(AccRdEn), .AccRdXIdx(AccRdXIdx), .AccRdYIdx(AccRdYIdx),
    .AccRdData(AccRdData),
    .RszPxlData(RszPxlData), .RszPxlXIdx(RszPxlXIdx), .RszPxlYIdx(RszPxlYIdx),
    .RszPxlVld(RszPxlVld), .RszPxlRdy(RszPxlRdy), .RszFrmDone(RszFrmDone)
  );

  always #5 Clk = ~Clk;

  // Accumulator memory responder: one-cycle read latency.
  always @(posedge Clk) begin
    if (AccRdEn) AccRdData <= mem[AccRdXIdx][AccRdYIdx];
  end

  function automatic int model_avg(input int sum);
    int a;
`ifdef RSZ_COMP_ROUND_EN
    a = (sum + 2) / 4;
`else
    a = sum / 4;
`endif
    return (a > 255) ? 255 : a;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Issue one block starting in an IDLE cycle; optional stall of the output for 'stall' cycles.
  task automatic do_block(input int x, input int y, input int stall);
    int exp_pxl;
    int exp_done;
    exp_pxl = model_avg(int'(mem[x][y]));
    CompBlkXIdx = x[RSZ_IMG_WIDTH_IDX_W-1:0];
    CompBlkYIdx = y[RSZ_IMG_HEIGHT_IDX_W-1:0];
    CompBlkVld = 1'b1;
    RszPxlRdy = (stall == 0);
    #1;
    checks++;
    if (CompBlkRdy !== 1'b1 || AccRdEn !== 1'b1 || AccRdXIdx !== CompBlkXIdx || AccRdYIdx !== CompBlkYIdx) begin
      failures++;
      $display("FAIL req_hs: rdy=%b en=%b addr=(%0d,%0d) want rdy=1 en=1 addr=(%0d,%0d)",
               CompBlkRdy, AccRdEn, AccRdXIdx, AccRdYIdx, x, y);
    end
    step();
    CompBlkVld = 1'b0;
    #1;
    checks++;
    if (RszPxlVld !== 1'b0 || AccRdEn !== 1'b0 || CompBlkRdy !== 1'b0 || RszFrmDone !== 1'b0) begin
      failures++;
      $display("FAIL rd_wait: vld=%b en=%b rdy=%b done=%b want all 0", RszPxlVld, AccRdEn, CompBlkRdy, RszFrmDone);
    end
    step();
    checks++;
    if (RszPxlVld !== 1'b0) begin
      failures++;
      $display("FAIL calc_vld: vld=%b want 0", RszPxlVld);
    end
    step();
    if (stall > 0) begin
      // Scheduler presents the next request while the output is stalled.
      CompBlkXIdx = 2'd2;
      CompBlkYIdx = 2'd1;
      CompBlkVld = 1'b1;
      for (int i = 0; i < stall; i++) begin
        #1;
        checks++;
        if (RszPxlVld !== 1'b1 || RszPxlData !== exp_pxl[7:0] || int'(RszPxlXIdx) != x ||
            int'(RszPxlYIdx) != y || CompBlkRdy !== 1'b0 || AccRdEn !== 1'b0 || RszFrmDone !== 1'b0) begin
          failures++;
          $display("FAIL stall_hold[%0d]: vld=%b data=%0d xy=(%0d,%0d) rdy=%b en=%b done=%b want 1,%0d,(%0d,%0d),0,0,0",
                   i, RszPxlVld, RszPxlData, RszPxlXIdx, RszPxlYIdx, CompBlkRdy, AccRdEn, RszFrmDone, exp_pxl, x, y);
        end
        step();
      end
      RszPxlRdy = 1'b1;
    end
    #1;
    exp_done = (m_cnt == N - 1) ? 1 : 0;
    checks++;
    if (RszPxlVld !== 1'b1 || RszPxlData !== exp_pxl[7:0] || int'(RszPxlXIdx) != x ||
        int'(RszPxlYIdx) != y || RszFrmDone !== exp_done[0]) begin
      failures++;
      $display("FAIL out_pxl: vld=%b data=%0d xy=(%0d,%0d) done=%b want 1,%0d,(%0d,%0d),%0d",
               RszPxlVld, RszPxlData, RszPxlXIdx, RszPxlYIdx, RszFrmDone, exp_pxl, x, y, exp_done);
    end
    if (RszFrmDone === 1'b1) done_seen++;
    m_cnt = (m_cnt + 1) % N;
    step();
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    step();
    step();
    checks++;
    if (CompBlkRdy !== 1'b1 || RszPxlVld !== 1'b0 || AccRdEn !== 1'b0 || RszFrmDone !== 1'b0 ||
        RszPxlData !== 8'd0 || RszPxlXIdx !== '0 || RszPxlYIdx !== '0) begin
      failures++;
      $display("FAIL reset: rdy=%b vld=%b en=%b done=%b data=%0d want 1,0,0,0,0", CompBlkRdy, RszPxlVld,
               AccRdEn, RszFrmDone, RszPxlData);
    end
    Reset = 1'b1;
    step();
    m_cnt = 0;
  endtask

  task automatic test_basic();
    mem[1][2] = 10'd1020;
    do_block(1, 2, 0);
    mem[3][0] = 10'd6;
    do_block(3, 0, 0);
    mem[0][1] = 10'd1023;
    do_block(0, 1, 0);
    mem[2][2] = 10'd0;
    do_block(2, 2, 0);
  endtask

  task automatic test_stall();
    mem[1][1] = 10'($urandom_range(0, 1023));
    mem[2][1] = 10'($urandom_range(0, 1023));
    do_block(1, 1, 5);
    // Held request (2,1) is accepted in the cycle after the stalled pixel leaves.
    do_block(2, 1, 0);
  endtask

  task automatic test_reset_mid();
    mem[0][0] = 10'd500;
    CompBlkXIdx = '0;
    CompBlkYIdx = '0;
    CompBlkVld = 1'b1;
    step();
    CompBlkVld = 1'b0;
    step();
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (RszPxlVld !== 1'b0 || CompBlkRdy !== 1'b1) begin
        failures++;
        $display("FAIL reset_mid[%0d]: vld=%b rdy=%b want 0,1", i, RszPxlVld, CompBlkRdy);
      end
      step();
    end
    m_cnt = 0;
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      done_seen = 0;
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          mem[x][y] = 10'($urandom_range(0, 1023));
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          do_block(x, y, 0);
      checks++;
      if (done_seen != 1) begin
        failures++;
        $display("FAIL frame_done_count[%0d]: got %0d want 1", f, done_seen);
      end
    end
  endtask

  initial begin
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        mem[x][y] = '0;
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
